// File: rtl/alu_pkg.sv
// alu_pkg: opcode, FSM state and width definitions shared by the sequential ALU array
package alu_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_MUL   = 3'b010,
    OP_CMP   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_XOR   = 3'b110,
    OP_PASSA = 3'b111
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} alu_state_e;
endpackage

// File: rtl/alu_lane_seq.sv
// alu_lane_seq: one ALU lane with operand capture, shift-add multiplier and result/flag registers (ALU_SAT_EN saturates ADD/SUB)
module alu_lane_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               load,
  input  logic               step,
  input  logic               last,
  input  alu_op_e            op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] out,
  output logic               carry,
  output logic               gt,
  output logic               eq,
  output logic               lt
);
  logic [2*WIDTH-1:0] mcand, acc, acc_nx;
  logic [WIDTH-1:0] mplier, add_r, sub_r, res;
  logic [WIDTH:0] sum, dif;
  logic cy;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
`ifdef ALU_SAT_EN
  assign add_r = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  assign sub_r = dif[WIDTH] ? '0 : dif[WIDTH-1:0];
`else
  assign add_r = sum[WIDTH-1:0];
  assign sub_r = dif[WIDTH-1:0];
`endif
  assign acc_nx = mplier[0] ? acc + mcand : acc;
  always_comb begin
    res = op == OP_ADD ? add_r : op == OP_SUB ? sub_r : op == OP_AND ? a & b :
          op == OP_OR ? a | b : op == OP_XOR ? a ^ b : op == OP_PASSA ? a : '0;
    cy = op == OP_ADD ? sum[WIDTH] : op == OP_SUB ? dif[WIDTH] : 1'b0;
  end
  always_ff @(posedge clk)
    if (!arst) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      out <= '0;
      carry <= 1'b0;
      gt <= 1'b0;
      eq <= 1'b0;
      lt <= 1'b0;
    end else if (load) begin
      acc <= '0;
      mcand <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      out <= {{WIDTH{1'b0}}, res};
      carry <= cy;
      gt <= a > b;
      eq <= a == b;
      lt <= a < b;
    end else if (step) begin
      acc <= acc_nx;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      if (last) out <= acc_nx;
    end
endmodule

// File: rtl/alu_array_seq.sv
// alu_array_seq: N_ALU-lane sequential ALU sharing one opcode and valid/ready handshake (ALU_SAT_EN saturates ADD/SUB)
module alu_array_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N_ALU = 4
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          select,
  input  logic [WIDTH*N_ALU-1:0]   a,
  input  logic [WIDTH*N_ALU-1:0]   b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH*N_ALU-1:0] out,
  output logic [N_ALU-1:0]         carry_out,
  output logic [N_ALU-1:0]         a_greater,
  output logic [N_ALU-1:0]         a_equal,
  output logic [N_ALU-1:0]         a_less
);
  localparam int CW = $clog2(WIDTH + 1);
  alu_state_e state, nxt;
  logic [CW-1:0] cnt;
  logic load, step, last;
  assign load = enable && in_valid && in_ready;
  assign step = enable && state == EXEC;
  assign last = cnt == CW'(WIDTH - 1);
  always_comb
    nxt = !enable ? state :
          state == IDLE ? (load ? (alu_op_e'(select) == OP_MUL ? EXEC : DONE) : IDLE) :
          state == EXEC ? (last ? DONE : EXEC) :
          (out_ready ? IDLE : DONE);
  always_ff @(posedge clk)
    if (!arst) begin
      state <= IDLE;
      cnt <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= nxt;
      in_ready <= nxt == IDLE;
      out_valid <= nxt == DONE;
      cnt <= step ? (last ? '0 : cnt + CW'(1)) : cnt;
    end
  for (genvar i = 0; i < N_ALU; i++) begin : g_lane
    alu_lane_seq #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .arst  (arst),
      .load  (load),
      .step  (step),
      .last  (last),
      .op    (alu_op_e'(select)),
      .a     (a[i*WIDTH +: WIDTH]),
      .b     (b[i*WIDTH +: WIDTH]),
      .out   (out[i*2*WIDTH +: 2*WIDTH]),
      .carry (carry_out[i]),
      .gt    (a_greater[i]),
      .eq    (a_equal[i]),
      .lt    (a_less[i])
    );
  end
endmodule
